// File: rtl/acc_pkg.sv
// Shared types and constants for the partial-sum accumulator: lane geometry, packed
// 4x16 vector type, FSM state encoding and the per-lane saturation helper.
package acc_pkg;

  localparam int unsigned PSUM_LANES = 4;
  localparam int unsigned PSUM_W     = 16;
  localparam int unsigned PSUM_VEC_W = PSUM_LANES * PSUM_W;

  typedef logic [PSUM_LANES-1:0][PSUM_W-1:0] psum_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } psum_acc_state_e;

  // Clamp a 17-bit signed lane sum into the 16-bit signed range.
  function automatic logic [PSUM_W-1:0] psum_sat(input logic [PSUM_W:0] v);
    if (v[PSUM_W] != v[PSUM_W-1]) begin
      return v[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
    end
    return v[PSUM_W-1:0];
  endfunction

endpackage

// File: rtl/psum_lane_add.sv
// Four independent 16-bit signed lane adders with no carry between lanes.
// Define PSUM_ACC_SAT_EN to saturate each lane; otherwise lanes wrap.
module psum_lane_add
  import acc_pkg::*;
(
  input  logic [PSUM_VEC_W-1:0] a,
  input  logic [PSUM_VEC_W-1:0] b,
  output logic [PSUM_VEC_W-1:0] sum
);

  psum_vec_t a_v, b_v, s_v;

  assign a_v = a;
  assign b_v = b;
  assign sum = s_v;

  always_comb begin
    s_v = '0;
    for (int i = 0; i < PSUM_LANES; i++) begin
`ifdef PSUM_ACC_SAT_EN
      s_v[i] = psum_sat({a_v[i][PSUM_W-1], a_v[i]} + {b_v[i][PSUM_W-1], b_v[i]});
`else
      s_v[i] = a_v[i] + b_v[i];
`endif
    end
  end

endmodule

// File: rtl/psum_acc.sv
// Partial-sum accumulator: sums 4-lane psums over cfg_pass_num passes into a per-pixel
// buffer and streams final sums to map_merger. Lane arithmetic honours PSUM_ACC_SAT_EN.
module psum_acc
  import acc_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_vld,
  output logic                  cfg_rdy,
  input  logic [ADDR_W:0]       cfg_pix_num,
  input  logic [7:0]            cfg_pass_num,
  input  logic [PSUM_VEC_W-1:0] pe2psum_acc_data,
  input  logic                  pe2psum_acc_vld,
  output logic                  pe2psum_acc_rdy,
  output logic [PSUM_VEC_W-1:0] psum_acc2map_merger_data,
  output logic                  psum_acc2map_merger_vld,
  input  logic                  psum_acc2map_merger_rdy,
  output logic                  psum_acc_done
);

  psum_acc_state_e       state_q;
  logic [ADDR_W:0]       cfg_pix_q;
  logic [7:0]            cfg_pass_q;
  logic [ADDR_W:0]       pix_cnt_q;
  logic [7:0]            pass_cnt_q;
  logic [PSUM_VEC_W-1:0] buf_q [DEPTH];
  logic [PSUM_VEC_W-1:0] out_data_q;
  logic                  out_vld_q;
  logic                  done_q;

  logic [ADDR_W:0]       pix_max;
  logic [7:0]            pass_max;
  logic                  last_pass;
  logic                  last_pix;
  logic                  in_fire;
  logic                  out_fire;
  logic [ADDR_W-1:0]     buf_addr;
  logic [PSUM_VEC_W-1:0] acc_base;
  logic [PSUM_VEC_W-1:0] acc_sum;

  assign pix_max   = cfg_pix_q - {{ADDR_W{1'b0}}, 1'b1};
  assign pass_max  = cfg_pass_q - 8'd1;
  assign last_pass = (pass_cnt_q == pass_max);
  assign last_pix  = (pix_cnt_q == pix_max);
  assign buf_addr  = pix_cnt_q[ADDR_W-1:0];

  // Last pass may only accept when the output register is free or draining this cycle.
  assign pe2psum_acc_rdy = (state_q == ACC) &&
                           (!last_pass || !out_vld_q || psum_acc2map_merger_rdy);
  assign in_fire  = pe2psum_acc_vld && pe2psum_acc_rdy;
  assign out_fire = out_vld_q && psum_acc2map_merger_rdy;

  // Pass 0 ignores stale buffer contents by adding to zero.
  assign acc_base = (pass_cnt_q == 8'd0) ? '0 : buf_q[buf_addr];

  psum_lane_add u_lane_add (
    .a   (acc_base),
    .b   (pe2psum_acc_data),
    .sum (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cfg_pix_q  <= '0;
      cfg_pass_q <= '0;
      pix_cnt_q  <= '0;
      pass_cnt_q <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_fire) begin
        out_vld_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (cfg_vld) begin
            cfg_pix_q  <= cfg_pix_num;
            cfg_pass_q <= cfg_pass_num;
            pix_cnt_q  <= '0;
            pass_cnt_q <= '0;
            if ((cfg_pix_num == '0) || (cfg_pass_num == 8'd0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (in_fire) begin
            if (last_pass) begin
              out_data_q <= acc_sum;
              out_vld_q  <= 1'b1;
            end
            if (last_pix) begin
              pix_cnt_q  <= '0;
              pass_cnt_q <= pass_cnt_q + 8'd1;
              if (last_pass) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end else begin
              pix_cnt_q <= pix_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Buffer holds running sums only; the last pass goes straight to the output register.
  always_ff @(posedge clk) begin
    if (!rst && in_fire && !last_pass) begin
      buf_q[buf_addr] <= acc_sum;
    end
  end

  assign cfg_rdy                  = !rst && (state_q == IDLE);
  assign psum_acc2map_merger_data = out_data_q;
  assign psum_acc2map_merger_vld  = out_vld_q;
  assign psum_acc_done            = done_q;

endmodule
